// File: rtl/agu_ls_unit.sv
// Single-issue AGU + load/store unit: one memory access at a time over req/ack,
// results broadcast on the LS wakeup bus, with a 1-entry skid for a late issue.
module agu_ls_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_op_awake,
  input  logic [4:0]        Pa_awake,
  input  logic [4:0]        Imm_awake,
  input  logic [4:0]        tag_ROB_awake,
  input  logic              mode_in,
  input  logic [4:0]        Pw_in,
  input  logic [4:0]        Pb_in,
  output logic              busy,
  output logic [4:0]        rd_addr_a,
  output logic [4:0]        rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              valid_Result_ls,
  output logic [4:0]        Pw_Result_ls,
  output logic              mode_ls,
  output logic [4:0]        tag_ROB_ls,
  output logic [DATA_W-1:0] data_Result_ls
);

  typedef enum logic [1:0] {IDLE, MEM, BCAST} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic              mode_q, mode_d;
  logic [4:0]        pw_q, pw_d, tag_q, tag_d;

  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_addr_q, skid_addr_d, skid_wdata_q, skid_wdata_d;
  logic              skid_mode_q, skid_mode_d;
  logic [4:0]        skid_pw_q, skid_pw_d, skid_tag_q, skid_tag_d;

  logic [DATA_W-1:0] cap_addr;

  assign rd_addr_a = Pa_awake;
  assign rd_addr_b = Pb_in;
  assign cap_addr  = rd_data_a + {{(DATA_W-5){1'b0}}, Imm_awake};

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    mode_d       = mode_q;
    pw_d         = pw_q;
    tag_d        = tag_q;
    skid_vld_d   = skid_vld_q;
    skid_addr_d  = skid_addr_q;
    skid_wdata_d = skid_wdata_q;
    skid_mode_d  = skid_mode_q;
    skid_pw_d    = skid_pw_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      state_d    = IDLE;
      skid_vld_d = 1'b0;
    end else begin
      // An op arriving while the unit is occupied parks in the skid.
      if (state_q != IDLE && valid_op_awake && !skid_vld_q) begin
        skid_vld_d   = 1'b1;
        skid_addr_d  = cap_addr;
        skid_wdata_d = rd_data_b;
        skid_mode_d  = mode_in;
        skid_pw_d    = Pw_in;
        skid_tag_d   = tag_ROB_awake;
      end
      case (state_q)
        IDLE: begin
          if (skid_vld_q) begin
            state_d    = MEM;
            addr_d     = skid_addr_q;
            wdata_d    = skid_wdata_q;
            mode_d     = skid_mode_q;
            pw_d       = skid_pw_q;
            tag_d      = skid_tag_q;
            skid_vld_d = 1'b0;
          end else if (valid_op_awake) begin
            state_d = MEM;
            addr_d  = cap_addr;
            wdata_d = rd_data_b;
            mode_d  = mode_in;
            pw_d    = Pw_in;
            tag_d   = tag_ROB_awake;
          end
        end
        MEM: begin
          if (mem_ack) begin
            state_d = BCAST;
            rdata_d = mem_rdata;
          end
        end
        BCAST: begin
          if (skid_vld_q) begin
            state_d    = MEM;
            addr_d     = skid_addr_q;
            wdata_d    = skid_wdata_q;
            mode_d     = skid_mode_q;
            pw_d       = skid_pw_q;
            tag_d      = skid_tag_q;
            skid_vld_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      mode_q       <= 1'b0;
      pw_q         <= '0;
      tag_q        <= '0;
      skid_vld_q   <= 1'b0;
      skid_addr_q  <= '0;
      skid_wdata_q <= '0;
      skid_mode_q  <= 1'b0;
      skid_pw_q    <= '0;
      skid_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      mode_q       <= mode_d;
      pw_q         <= pw_d;
      tag_q        <= tag_d;
      skid_vld_q   <= skid_vld_d;
      skid_addr_q  <= skid_addr_d;
      skid_wdata_q <= skid_wdata_d;
      skid_mode_q  <= skid_mode_d;
      skid_pw_q    <= skid_pw_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  // Outputs decode from flops only, so nothing follows mem_ack combinationally.
  assign busy            = (state_q != IDLE) | skid_vld_q;
  assign mem_req         = (state_q == MEM);
  assign mem_we          = mem_req & ~mode_q;
  assign mem_addr        = mem_req ? addr_q  : '0;
  assign mem_wdata       = mem_req ? wdata_q : '0;
  assign valid_Result_ls = (state_q == BCAST);
  assign Pw_Result_ls    = valid_Result_ls ? pw_q  : '0;
  assign mode_ls         = valid_Result_ls & mode_q;
  assign tag_ROB_ls      = valid_Result_ls ? tag_q : '0;
  assign data_Result_ls  = (valid_Result_ls && mode_q) ? rdata_q : '0;

endmodule

// File: tb/tb_agu_ls_unit.sv
// Self-checking bench for agu_ls_unit: directed scenarios plus randomized ops
// checked against an arithmetic model of address generation and broadcast.
module tb_agu_ls_unit;
  logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, valid_op_awake = 1'b0;
  logic [4:0]  Pa_awake = '0, Imm_awake = '0, tag_ROB_awake = '0, Pw_in = '0, Pb_in = '0;
  logic        mode_in = 1'b0, mem_ack = 1'b0;
  logic [31:0] rd_data_a = '0, rd_data_b = '0, mem_rdata = '0;
  logic        busy, mem_req, mem_we, valid_Result_ls, mode_ls;
  logic [4:0]  rd_addr_a, rd_addr_b, Pw_Result_ls, tag_ROB_ls;
  logic [31:0] mem_addr, mem_wdata, data_Result_ls;

  int checks = 0, failures = 0;

  agu_ls_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_op_awake(valid_op_awake),
    .Pa_awake(Pa_awake), .Imm_awake(Imm_awake), .tag_ROB_awake(tag_ROB_awake),
    .mode_in(mode_in), .Pw_in(Pw_in), .Pb_in(Pb_in), .busy(busy),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_Result_ls(valid_Result_ls), .Pw_Result_ls(Pw_Result_ls), .mode_ls(mode_ls),
    .tag_ROB_ls(tag_ROB_ls), .data_Result_ls(data_Result_ls)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Each cycle: sample outputs 1 time unit after the edge, then drive inputs.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [4:0] imm, input logic [31:0] b,
                       input logic mode, input logic [4:0] pw, input logic [4:0] tag);
    valid_op_awake = 1'b1;
    Pa_awake = 5'($urandom); Pb_in = 5'($urandom);
    rd_data_a = a; Imm_awake = imm; rd_data_b = b;
    mode_in = mode; Pw_in = pw; tag_ROB_awake = tag;
  endtask

  // One isolated op: issue in T, ack on the lat-th MEM cycle, broadcast after.
  task automatic do_op(input logic [31:0] a, input logic [4:0] imm, input logic [31:0] b,
                       input logic mode, input logic [4:0] pw, input logic [4:0] tag,
                       input int lat, input string nm);
    logic [31:0] ea, rdata, exp_data;
    ea = a + {27'd0, imm};
    rdata = $urandom;
    exp_data = mode ? rdata : 32'd0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL %s busy_before_issue act=%0b exp=0", nm, busy);
    end
    issue(a, imm, b, mode, pw, tag);
    #1;
    checks++;
    if ({rd_addr_a, rd_addr_b} !== {Pa_awake, Pb_in}) begin
      failures++; $display("FAIL %s rd_addr act=%0h/%0h exp=%0h/%0h", nm, rd_addr_a, rd_addr_b, Pa_awake, Pb_in);
    end
    tick();
    valid_op_awake = 1'b0;
    for (int i = 0; i < lat; i++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, busy, valid_Result_ls} !== {1'b1, ~mode, ea, b, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL %s mem_cycle%0d act req=%0b we=%0b addr=%0h wd=%0h busy=%0b v=%0b exp req=1 we=%0b addr=%0h wd=%0h busy=1 v=0",
                 nm, i, mem_req, mem_we, mem_addr, mem_wdata, busy, valid_Result_ls, ~mode, ea, b);
      end
      mem_ack = (i == lat - 1);
      mem_rdata = (i == lat - 1) ? rdata : $urandom;
      tick();
      mem_ack = 1'b0;
    end
    checks++;
    if ({valid_Result_ls, Pw_Result_ls, mode_ls, tag_ROB_ls, data_Result_ls, mem_req} !== {1'b1, pw, mode, tag, exp_data, 1'b0}) begin
      failures++;
      $display("FAIL %s bcast act v=%0b pw=%0d m=%0b tag=%0d d=%0h req=%0b exp v=1 pw=%0d m=%0b tag=%0d d=%0h req=0",
               nm, valid_Result_ls, Pw_Result_ls, mode_ls, tag_ROB_ls, data_Result_ls, mem_req, pw, mode, tag, exp_data);
    end
    tick();
    checks++;
    if ({valid_Result_ls, busy, mem_req} !== 3'b000) begin
      failures++; $display("FAIL %s after_bcast act v=%0b busy=%0b req=%0b exp 0/0/0", nm, valid_Result_ls, busy, mem_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({busy, mem_req, mem_we, mem_addr, mem_wdata, valid_Result_ls, Pw_Result_ls, mode_ls, tag_ROB_ls, data_Result_ls} !== '0) begin
      failures++; $display("FAIL reset outputs act req=%0b busy=%0b v=%0b addr=%0h exp all 0", mem_req, busy, valid_Result_ls, mem_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, mem_req, valid_Result_ls} !== 3'b000) begin
      failures++; $display("FAIL reset_release act busy=%0b req=%0b v=%0b exp 0", busy, mem_req, valid_Result_ls);
    end
  endtask

  task automatic test_load();  do_op(32'h100, 5'd4, 32'h0, 1'b1, 5'd7, 5'd2, 1, "load"); endtask
  task automatic test_store(); do_op(32'h20, 5'd0, 32'h55, 1'b0, 5'd9, 5'd3, 1, "store"); endtask
  task automatic test_wait();  do_op(32'h4000, 5'd31, 32'hCAFE, 1'b1, 5'd4, 5'd6, 4, "wait"); endtask
  task automatic test_wrap();  do_op(32'hFFFF_FFFE, 5'd3, 32'h1234, 1'b0, 5'd1, 5'd8, 2, "wrap"); endtask

  task automatic test_skid();
    logic [31:0] ra;
    ra = $urandom;
    tick();
    issue(32'h1000, 5'd8, 32'h0, 1'b1, 5'd3, 5'd1);
    tick();
    checks++;
    if ({mem_req, mem_addr, busy} !== {1'b1, 32'h1008, 1'b1}) begin
      failures++; $display("FAIL skid A_mem act req=%0b addr=%0h busy=%0b exp 1/1008/1", mem_req, mem_addr, busy);
    end
    issue(32'h2000, 5'd1, 32'hBEEF, 1'b0, 5'd5, 5'd2);
    mem_ack = 1'b1; mem_rdata = ra;
    tick();
    valid_op_awake = 1'b0; mem_ack = 1'b0;
    checks++;
    if ({valid_Result_ls, tag_ROB_ls, mode_ls, data_Result_ls, mem_req, busy} !== {1'b1, 5'd1, 1'b1, ra, 1'b0, 1'b1}) begin
      failures++; $display("FAIL skid A_bcast act v=%0b tag=%0d d=%0h req=%0b busy=%0b exp 1/1/%0h/0/1",
                           valid_Result_ls, tag_ROB_ls, data_Result_ls, mem_req, busy, ra);
    end
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, busy, valid_Result_ls} !== {1'b1, 1'b1, 32'h2001, 32'hBEEF, 1'b1, 1'b0}) begin
      failures++; $display("FAIL skid B_mem act req=%0b we=%0b addr=%0h wd=%0h busy=%0b v=%0b exp 1/1/2001/beef/1/0",
                           mem_req, mem_we, mem_addr, mem_wdata, busy, valid_Result_ls);
    end
    mem_ack = 1'b1; mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({valid_Result_ls, tag_ROB_ls, Pw_Result_ls, mode_ls, data_Result_ls, busy} !== {1'b1, 5'd2, 5'd5, 1'b0, 32'd0, 1'b1}) begin
      failures++; $display("FAIL skid B_bcast act v=%0b tag=%0d pw=%0d m=%0b d=%0h busy=%0b exp 1/2/5/0/0/1",
                           valid_Result_ls, tag_ROB_ls, Pw_Result_ls, mode_ls, data_Result_ls, busy);
    end
    tick();
    checks++;
    if ({busy, valid_Result_ls, mem_req} !== 3'b000) begin
      failures++; $display("FAIL skid done act busy=%0b v=%0b req=%0b exp 0", busy, valid_Result_ls, mem_req);
    end
  endtask

  task automatic test_flush();
    tick();
    issue(32'h300, 5'd2, 32'h0, 1'b1, 5'd2, 5'd10);
    tick();
    issue(32'h400, 5'd2, 32'h77, 1'b0, 5'd3, 5'd11);
    tick();
    checks++;
    if ({mem_req, busy} !== 2'b11) begin
      failures++; $display("FAIL flush pre act req=%0b busy=%0b exp 1/1", mem_req, busy);
    end
    flush = 1'b1;
    issue(32'h500, 5'd0, 32'h0, 1'b1, 5'd4, 5'd12);
    tick();
    flush = 1'b0; valid_op_awake = 1'b0;
    mem_ack = 1'b1; mem_rdata = $urandom;
    checks++;
    if ({mem_req, busy, valid_Result_ls} !== 3'b000) begin
      failures++; $display("FAIL flush next act req=%0b busy=%0b v=%0b exp 0", mem_req, busy, valid_Result_ls);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({mem_req, busy, valid_Result_ls} !== 3'b000) begin
        failures++; $display("FAIL flush late%0d act req=%0b busy=%0b v=%0b exp 0", i, mem_req, busy, valid_Result_ls);
      end
    end
    do_op(32'h600, 5'd1, 32'h9, 1'b1, 5'd6, 5'd13, 1, "post_flush");
  endtask

  task automatic test_reset_mid();
    tick();
    issue(32'h700, 5'd5, 32'h42, 1'b0, 5'd2, 5'd14);
    tick();
    valid_op_awake = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL rst_mid pre act req=%0b exp 1", mem_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, mem_req, mem_we, mem_addr, mem_wdata, valid_Result_ls, Pw_Result_ls, mode_ls, tag_ROB_ls, data_Result_ls} !== '0) begin
      failures++; $display("FAIL rst_mid outputs act req=%0b we=%0b addr=%0h busy=%0b exp all 0", mem_req, mem_we, mem_addr, busy);
    end
    tick();
    rst = 1'b1;
    do_op(32'h800, 5'd7, 32'h0, 1'b1, 5'd12, 5'd15, 2, "post_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++)
      do_op($urandom, 5'($urandom), $urandom, 1'($urandom), 5'($urandom), 5'($urandom),
            int'($urandom_range(1, 4)), "random");
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_wait();
    test_wrap();
    test_skid();
    test_flush();
    test_reset_mid();
    test_random();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
